// File: rtl/cbus_arbiter_pkg.sv
// Cache-bus request/response types shared by the cbus masters and arbiter.
// Also holds the arbiter state encoding.
package cbus_arbiter_pkg;

  typedef enum logic [1:0] {
    MSIZE1 = 2'd0,
    MSIZE2 = 2'd1,
    MSIZE4 = 2'd2
  } msize_t;

  // Encoded as beats-1
  typedef enum logic [7:0] {
    MLEN1  = 8'd0,
    MLEN2  = 8'd1,
    MLEN4  = 8'd3,
    MLEN8  = 8'd7,
    MLEN16 = 8'd15
  } mlen_t;

  typedef struct packed {
    logic        valid;
    logic        is_write;
    msize_t      size;
    logic [31:0] addr;
    logic [3:0]  strobe;
    logic [31:0] data;
    mlen_t       len;
  } cbus_req_t;

  typedef struct packed {
    logic        ready;
    logic        last;
    logic [31:0] data;
  } cbus_resp_t;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_e;

endpackage

// File: rtl/cbus_arbiter_rr_pick.sv
// Round-robin picker: first set bit of valid scanning from ptr, wrapping.
// Ports: valid (vector), ptr (start index) -> found, idx.
module cbus_arbiter_rr_pick #(
  parameter  int N = 2,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0] valid,
  input  logic [W-1:0] ptr,
  output logic         found,
  output logic [W-1:0] idx
);

  logic [W:0]   pos;
  logic [W-1:0] cand;

  // Scan from the far end down so the slot at ptr wins last.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    pos   = '0;
    cand  = '0;
    for (int k = N - 1; k >= 0; k--) begin
      pos = {1'b0, ptr} + (W+1)'(k);
      if (pos >= (W+1)'(N))
        pos = pos - (W+1)'(N);
      cand = pos[W-1:0];
      if (valid[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/cbus_arbiter.sv
// Round-robin cache-bus arbiter: N masters onto one bridge port, burst-locked.
// Ports: clk, reset, ireqs/iresps (masters), oreq/oresp (bridge), busy, grant_idx.
module cbus_arbiter
  import cbus_arbiter_pkg::*;
#(
  parameter  int NUM_MASTERS = 2,
  localparam int IDX_W       = $clog2(NUM_MASTERS)
) (
  input  logic             clk,
  input  logic             reset,
  input  cbus_req_t        ireqs  [NUM_MASTERS],
  output cbus_resp_t       iresps [NUM_MASTERS],
  output cbus_req_t        oreq,
  input  cbus_resp_t       oresp,
  output logic             busy,
  output logic [IDX_W-1:0] grant_idx
);

  arb_state_e             state_q, state_d;
  logic [IDX_W-1:0]       grant_q, grant_d;
  logic [IDX_W-1:0]       rr_q, rr_d;
  logic [NUM_MASTERS-1:0] req_vld;
  logic                   pick_found;
  logic [IDX_W-1:0]       pick_idx;
  logic                   done;

  always_comb begin
    req_vld = '0;
    for (int i = 0; i < NUM_MASTERS; i++)
      req_vld[i] = ireqs[i].valid;
  end

  cbus_arbiter_rr_pick #(
    .N (NUM_MASTERS)
  ) u_pick (
    .valid (req_vld),
    .ptr   (rr_q),
    .found (pick_found),
    .idx   (pick_idx)
  );

  // Release only on the final beat, even if the master
  // dropped valid mid-burst.
  assign done = oresp.ready & oresp.last;

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    rr_d    = rr_q;
    unique case (state_q)
      ARB_IDLE: begin
        if (pick_found) begin
          state_d = ARB_BUSY;
          grant_d = pick_idx;
        end
      end
      ARB_BUSY: begin
        if (done) begin
          state_d = ARB_IDLE;
          rr_d    = (grant_q == IDX_W'(NUM_MASTERS - 1))
                  ? '0 : grant_q + IDX_W'(1);
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ARB_IDLE;
      grant_q <= '0;
      rr_q    <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rr_q    <= rr_d;
    end
  end

  // Beat data flows straight through so it updates the same cycle.
  always_comb begin
    oreq = '0;
    for (int i = 0; i < NUM_MASTERS; i++)
      iresps[i] = '0;
    if (state_q == ARB_BUSY) begin
      oreq            = ireqs[grant_q];
      iresps[grant_q] = oresp;
    end
  end

  assign busy      = (state_q == ARB_BUSY);
  assign grant_idx = grant_q;

endmodule

// File: tb/tb_cbus_arbiter.sv
// Scoreboard bench for cbus_arbiter with a transaction-level arbitration model.
// Directed scenarios followed by a randomized master/bridge phase.
`timescale 1ns/1ps
module tb_cbus_arbiter;
  import cbus_arbiter_pkg::*;

  localparam int N = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  cbus_req_t  ireqs  [N];
  cbus_resp_t iresps [N];
  cbus_req_t  oreq;
  cbus_resp_t oresp;
  logic       busy;
  logic [0:0] grant_idx;

  always #5 clk = ~clk;

  cbus_arbiter #(.NUM_MASTERS(N)) dut (
    .clk       (clk),
    .reset     (reset),
    .ireqs     (ireqs),
    .iresps    (iresps),
    .oreq      (oreq),
    .oresp     (oresp),
    .busy      (busy),
    .grant_idx (grant_idx)
  );

  typedef struct {
    int          idx;
    logic [31:0] data;
    logic        last;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   gq[$];
  int   checks = 0;
  int   failures = 0;
  int   owner = -1;
  int   last_done = N - 1;
  int   pick;
  bit   mdone [N];
  bit   in_burst = 0;
  int   beats_left = 0;
  int   beat_no = 0;
  bit   brg_rand = 0;
  bit   brg_seq = 0;
  bit   pushed = 0;
  logic busy_prev = 1'b0;
  mlen_t lens [4] = '{MLEN1, MLEN2, MLEN4, MLEN8};

  task automatic chk(string nm, logic [127:0] act, logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic cbus_req_t mkreq(logic w, logic [31:0] a,
                                      logic [3:0] s, logic [31:0] d,
                                      mlen_t l);
    cbus_req_t r;
    r = '0;
    r.valid = 1'b1;
    r.is_write = w;
    r.size = MSIZE4;
    r.addr = a;
    r.strobe = s;
    r.data = d;
    r.len = l;
    return r;
  endfunction

  // Reference: one owner at a time; the next owner is the first
  // requester after the master that finished last.
  always @(posedge clk) begin
    if (reset) begin
      owner = -1;
      last_done = N - 1;
    end else if (owner < 0) begin
      pick = -1;
      for (int k = 1; k <= N; k++)
        if (pick < 0 && ireqs[(last_done + k) % N].valid)
          pick = (last_done + k) % N;
      owner = pick;
    end else if (oresp.ready && oresp.last) begin
      mdone[owner] = 1'b1;
      last_done = owner;
      owner = -1;
    end
  end

  // Bridge: serves len+1 beats to the owner, pushes expectations.
  always begin
    @(negedge clk);
    #1;
    oresp = '0;
    pushed = 0;
    if (reset || owner < 0) begin
      in_burst = 0;
    end else begin
      if (!in_burst) begin
        in_burst = 1;
        beats_left = int'(ireqs[owner].len) + 1;
        beat_no = 0;
      end
      if (!brg_rand || $urandom_range(0, 3) != 0) begin
        oresp.ready = 1'b1;
        oresp.last = (beats_left == 1);
        oresp.data = brg_seq ? 32'(32'hA0 + beat_no) : $urandom;
        beats_left--;
        beat_no++;
        if (oresp.last) in_burst = 0;
        exp_q.push_back('{owner, oresp.data, oresp.last});
        pushed = 1;
      end
    end
  end

  // Monitor
  always begin
    @(negedge clk);
    #2;
    chk("busy", busy, owner >= 0);
    if (owner >= 0) begin
      chk("grant_idx", grant_idx, owner);
      chk("oreq_pass", oreq, ireqs[owner]);
      chk("iresp_own", iresps[owner], oresp);
    end else begin
      chk("oreq_idle", oreq, '0);
    end
    for (int i = 0; i < N; i++) begin
      if (i != owner)
        chk("iresp_other", iresps[i], '0);
      if (iresps[i].ready) begin
        chk("resp_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("resp_idx", i, e.idx);
          chk("resp_data", iresps[i].data, e.data);
          chk("resp_last", iresps[i].last, e.last);
        end
      end
    end
    if (pushed)
      chk("resp_missing", exp_q.size(), 0);
    if (busy && !busy_prev)
      gq.push_back(int'(grant_idx));
    busy_prev = busy;
  end

  task automatic wait_done(int m, int budget, string nm);
    bit ok;
    ok = 0;
    for (int c = 0; c < budget && !ok; c++) begin
      @(negedge clk);
      if (mdone[m]) begin
        mdone[m] = 0;
        ok = 1;
      end
    end
    chk(nm, ok, 1);
  endtask

  task automatic gen_master(int i, bit allow_new);
    if (mdone[i]) begin
      mdone[i] = 0;
      ireqs[i] = '0;
    end
    if (allow_new && !ireqs[i].valid && $urandom_range(0, 3) == 0)
      ireqs[i] = mkreq(1'($urandom), $urandom, 4'($urandom),
                       $urandom, lens[$urandom_range(0, 3)]);
    if (ireqs[i].valid && owner == i)
      ireqs[i].data = $urandom;
  endtask

  initial begin
    int grants;
    int nb;
    bit drained;
    for (int i = 0; i < N; i++) begin
      ireqs[i] = '0;
      mdone[i] = 0;
    end
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    #3;
    chk("rst_busy", busy, 0);
    chk("rst_grant", grant_idx, 0);
    chk("rst_oreq", oreq, '0);

    // single master 1 read, A0..A3
    brg_seq = 1;
    brg_rand = 0;
    @(negedge clk);
    ireqs[1] = mkreq(1'b0, 32'h8000_0040, 4'hF, 32'h0, MLEN4);
    @(negedge clk);
    #3;
    chk("t2_latency", oreq.valid, 1);
    wait_done(1, 40, "t2_done");
    ireqs[1] = '0;

    // both valid at reset release: 0, 1, 0
    @(negedge clk);
    reset = 1'b1;
    ireqs[0] = mkreq(1'b0, 32'h100, 4'hF, 32'h0, MLEN4);
    ireqs[1] = mkreq(1'b0, 32'h200, 4'hF, 32'h0, MLEN4);
    mdone[0] = 0;
    mdone[1] = 0;
    repeat (2) @(negedge clk);
    gq.delete();
    reset = 1'b0;
    grants = 0;
    for (int c = 0; c < 200 && grants < 3; c++) begin
      @(negedge clk);
      for (int i = 0; i < N; i++)
        if (mdone[i]) begin
          mdone[i] = 0;
          grants++;
        end
      if (grants >= 3) begin
        ireqs[0] = '0;
        ireqs[1] = '0;
      end
    end
    chk("t3_grants", grants, 3);
    repeat (3) @(negedge clk);
    chk("t3_order_n", gq.size(), 3);
    if (gq.size() == 3) begin
      chk("t3_order0", gq[0], 0);
      chk("t3_order1", gq[1], 1);
      chk("t3_order2", gq[2], 0);
    end

    // master 1 uncached single-beat write
    @(negedge clk);
    ireqs[1] = mkreq(1'b1, 32'h1FAF_F000, 4'b0011, 32'h1234_5678, MLEN1);
    nb = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (mdone[1]) begin
        mdone[1] = 0;
        ireqs[1] = '0;
      end
      #3;
      if (busy) begin
        nb++;
        chk("t4_addr", oreq.addr, 32'h1FAF_F000);
        chk("t4_data", oreq.data, 32'h1234_5678);
        chk("t4_strobe", oreq.strobe, 4'b0011);
        chk("t4_write", oreq.is_write, 1);
        chk("t4_len", oreq.len, MLEN1);
      end
    end
    chk("t4_busy_cycles", nb, 1);

    // reset on beat 2 of a master-0 burst
    @(negedge clk);
    ireqs[0] = mkreq(1'b0, 32'h300, 4'hF, 32'h0, MLEN4);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    ireqs[0] = '0;
    @(negedge clk);
    #3;
    chk("t5_busy", busy, 0);
    chk("t5_valid", oreq.valid, 0);
    chk("t5_grant", grant_idx, 0);
    mdone[0] = 0;
    mdone[1] = 0;
    @(negedge clk);
    reset = 1'b0;

    // master 0 drops valid on beat 3; master 1 waits
    @(negedge clk);
    ireqs[0] = mkreq(1'b0, 32'h400, 4'hF, 32'h0, MLEN4);
    ireqs[1] = mkreq(1'b1, 32'h500, 4'hF, 32'hCAFE, MLEN2);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    ireqs[0].valid = 1'b0;
    #3;
    chk("t6_busy", busy, 1);
    chk("t6_grant", grant_idx, 0);
    chk("t6_fwd_valid", oreq.valid, 0);
    wait_done(0, 20, "t6_done0");
    ireqs[0] = '0;
    wait_done(1, 20, "t6_done1");
    ireqs[1] = '0;

    // random phase
    brg_seq = 0;
    brg_rand = 1;
    repeat (3000) begin
      @(negedge clk);
      for (int i = 0; i < N; i++) gen_master(i, 1);
    end
    drained = 0;
    for (int c = 0; c < 500 && !drained; c++) begin
      @(negedge clk);
      for (int i = 0; i < N; i++) gen_master(i, 0);
      drained = (owner < 0) && !ireqs[0].valid && !ireqs[1].valid;
    end
    chk("drain", drained, 1);
    repeat (3) @(negedge clk);
    chk("queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/cbus_arbiter.md
Name: cbus_arbiter

Overview:
- Downstream neighbour of the data cache. Merges the cache-bus requests of N masters (instruction cache, data cache) onto the single cache bus that feeds the memory/AXI bridge.
- Grants one master at a time, round-robin. A grant is held for the whole burst and released only on the final beat.
- All response traffic is routed back to the granted master only.

Parameters:
- NUM_MASTERS, 2, number of upstream cbus masters (index 0 = icache, 1 = dcache); legal range 2..4.
- IDX_W, $clog2(NUM_MASTERS), width of the grant index (derived, not overridden).

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- ireqs  input  NUM_MASTERS x cbus_req_t  per-master requests (valid, is_write, size, addr, strobe, data, len)
- iresps  output  NUM_MASTERS x cbus_resp_t  per-master responses (ready, last, data)
- oreq  output  cbus_req_t  request to memory bridge
- oresp  input  cbus_resp_t  response from memory bridge
- busy  output  1  a grant is currently held
- grant_idx  output  IDX_W  index of the granted master; valid only while busy=1

Behaviour:
- One clock, clk. reset is synchronous and active-high. Reset state:
  - state=IDLE, busy=0, grant_idx=0, rr_ptr=0.
  - oreq all-zero (valid=0).
  - every iresps[i] all-zero.
- States: IDLE, BUSY.
- IDLE:
  - oreq is all-zero and every iresps is all-zero.
  - Select the first i with ireqs[i].valid=1, scanning rr_ptr, rr_ptr+1, ... modulo NUM_MASTERS.
  - If one is found: next cycle state=BUSY, grant_idx=i.
  - If none is found: stay IDLE.
- BUSY:
  - oreq = ireqs[grant_idx], passed through combinationally so the master's beat data updates the same cycle.
  - iresps[grant_idx] = oresp. All other iresps are all-zero.
- BUSY -> IDLE when oresp.ready & oresp.last. On that edge, rr_ptr = (grant_idx+1) mod NUM_MASTERS.
- Latency: a request whose valid rises in IDLE appears on oreq exactly 1 cycle later. Minimum grant-to-grant turnaround is 1 IDLE cycle after last.
- Fairness:
  - A master that just finished has the lowest priority on the next arbitration.
  - With 2 masters both continuously valid, grants strictly alternate.
- Non-granted masters see ready=0 and last=0 until granted; they must hold their request stable (cbus rule).
- Simultaneous events:
  - A new request arriving on the cycle of last is not granted that cycle; it arbitrates in the following IDLE cycle.
  - The just-finished master re-requesting immediately only wins if no other master is valid.
- Granted master drops valid mid-burst (protocol violation): the arbiter stays BUSY and forwards valid=0. It releases only on oresp.ready & oresp.last, so it never re-grants mid-burst.
- Single-beat transfers (len=MLEN1, used by uncached accesses): ready & last in the same cycle returns to IDLE after 1 BUSY cycle.
- Reset asserted mid-burst: state=IDLE next cycle and oreq.valid drops. The bridge is reset by the same reset, so no orphan beat is tracked.
- rr_ptr wraps modulo NUM_MASTERS. For non-power-of-2 counts, an increment past NUM_MASTERS-1 yields 0.

Decomposition:
- cbus_req_t, cbus_resp_t, msize_t, mlen_t and MLEN1/MLEN4/MSIZE4 stay in the shared def.svh package; nothing new is added there.
- rr_pick is a natural combinational sub-module: inputs valid vector and rr_ptr; outputs found and index.
- The FSM, pointer and muxing live in cbus_arbiter.

Test Plan:
- Reset, then idle: no ireqs valid for 10 cycles -> oreq.valid=0, busy=0, every iresps zero.
- Single master 1, read of 0x8000_0040 with len=MLEN4: bridge gives 4 ready beats (0xA0..0xA3), last on the 4th:
  - oreq.valid=1 one cycle after the request.
  - iresps[1].data sequence is A0..A3, with last on beat 4.
  - iresps[0] stays zero.
  - busy=0 the cycle after last.
- Both masters valid at reset release, each a 4-beat burst -> master 0 is granted first, then master 1, then master 0 again; a 1-cycle IDLE gap between grants.
- Master 1 uncached write, len=MLEN1, addr 0x1FAF_F000, data 0x1234_5678, strobe 4'b0011:
  - oreq carries these fields unchanged.
  - ready & last on the first beat -> busy is high for exactly 1 cycle.
- Reset asserted on beat 2 of a master-0 burst -> next cycle oreq.valid=0, busy=0, grant_idx=0, rr_ptr=0.
- Master 0 drops valid on beat 3 of 4 -> busy stays 1 and grant_idx stays 0; master 1, valid throughout, is not granted until the oresp last beat.
